// File: rtl/simd_batch_scheduler.sv
// Frame sequencer: walks the output image in N-pixel batches, emits per-lane Q.8 source coords.
// Latency: cfg_start -> fetch_req two edges later; fetch_ack -> batch_start next cycle; done -> next batch two edges later.
// Backpressure: holds fetch_req and the descriptor until fetch_ack; holds in WAIT until batch_done.
module simd_batch_scheduler #(
  parameter int N     = 4,
  parameter int W_DIM = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_start,
  input  logic [W_DIM-1:0]     cfg_src_w,
  input  logic [W_DIM-1:0]     cfg_src_h,
  input  logic [W_DIM-1:0]     cfg_out_w,
  input  logic [W_DIM-1:0]     cfg_out_h,
  input  logic [15:0]          cfg_step_x,
  input  logic [15:0]          cfg_step_y,
  output logic                 fetch_req,
  input  logic                 fetch_ack,
  output logic                 batch_start,
  input  logic                 batch_done,
  output logic [N-1:0]         lane_valid,
  output logic [N*W_DIM-1:0]   lane_src_x,
  output logic [N*8-1:0]       lane_alpha,
  output logic [W_DIM-1:0]     src_y,
  output logic [7:0]           beta,
  output logic [W_DIM-1:0]     dst_x,
  output logic [W_DIM-1:0]     dst_y,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int AW = W_DIM + 8;
  localparam logic [W_DIM-1:0] ONE_W = W_DIM'(1);
  localparam logic [W_DIM-1:0] TWO_W = W_DIM'(2);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_FETCH, S_ISSUE, S_WAIT, S_ADVANCE, S_DONE
  } state_t;

  state_t           r_state;
  logic [W_DIM-1:0] r_src_w, r_src_h, r_out_w, r_out_h;
  logic [AW-1:0]    r_step_x, r_step_y;
  logic [AW-1:0]    r_acc_x;   // dst_x * step_x, lane 0 of current batch
  logic [AW-1:0]    r_acc_y;   // dst_y * step_y

  logic [W_DIM-1:0] w_src_w, w_src_h, w_out_w, w_out_h;
  logic [AW-1:0]    w_step_x, w_step_y;
  logic [W_DIM:0]   w_dx_n, w_dy_1, w_lx;
  logic [AW-1:0]    w_adv_x, w_lacc;
  logic             w_row_more, w_frame_end, w_empty;
  logic [W_DIM-1:0] w_nx_dst_x, w_nx_dst_y, w_xi, w_yi;
  logic [AW-1:0]    w_nx_acc_x, w_nx_acc_y;
  logic [N-1:0]     w_vld;
  logic [N*W_DIM-1:0] w_src_x;
  logic [N*8-1:0]   w_alpha;
  logic [W_DIM-1:0] w_src_y;
  logic [7:0]       w_beta;

  // Next batch position and its clamped descriptor; INIT reads cfg directly since it latches it on the same edge
  always_comb begin
    w_src_w  = r_src_w;
    w_src_h  = r_src_h;
    w_out_w  = r_out_w;
    w_out_h  = r_out_h;
    w_step_x = r_step_x;
    w_step_y = r_step_y;
    if (r_state == S_INIT) begin
      w_src_w  = cfg_src_w;
      w_src_h  = cfg_src_h;
      w_out_w  = cfg_out_w;
      w_out_h  = cfg_out_h;
      w_step_x = AW'(cfg_step_x);
      w_step_y = AW'(cfg_step_y);
    end
    w_empty = (cfg_out_w == '0) || (cfg_out_h == '0);

    // Advancing by N columns adds step_x N times; no multiplier needed
    w_adv_x = r_acc_x;
    for (int i = 0; i < N; i++) w_adv_x = w_adv_x + w_step_x;
    w_dx_n      = {1'b0, dst_x} + (W_DIM+1)'(N);
    w_dy_1      = {1'b0, dst_y} + (W_DIM+1)'(1);
    w_row_more  = w_dx_n < {1'b0, w_out_w};
    w_frame_end = !w_row_more && (w_dy_1 >= {1'b0, w_out_h});

    if (r_state == S_INIT) begin
      w_nx_dst_x = '0;
      w_nx_dst_y = '0;
      w_nx_acc_x = '0;
      w_nx_acc_y = '0;
    end else if (w_row_more) begin
      w_nx_dst_x = w_dx_n[W_DIM-1:0];
      w_nx_dst_y = dst_y;
      w_nx_acc_x = w_adv_x;
      w_nx_acc_y = r_acc_y;
    end else begin
      w_nx_dst_x = '0;
      w_nx_dst_y = w_dy_1[W_DIM-1:0];
      w_nx_acc_x = '0;
      w_nx_acc_y = r_acc_y + w_step_y;
    end

    // Clamp keeps the 2x2 neighbourhood inside the source image
    w_yi = w_nx_acc_y[AW-1:8];
    if (w_yi >= w_src_h - ONE_W) begin
      w_src_y = w_src_h - TWO_W;
      w_beta  = 8'hFF;
    end else begin
      w_src_y = w_yi;
      w_beta  = w_nx_acc_y[7:0];
    end

    w_lacc  = w_nx_acc_x;
    w_lx    = '0;
    w_xi    = '0;
    w_vld   = '0;
    w_src_x = '0;
    w_alpha = '0;
    for (int i = 0; i < N; i++) begin
      w_lx   = {1'b0, w_nx_dst_x} + (W_DIM+1)'(i);
      w_xi   = w_lacc[AW-1:8];
      w_vld[i] = w_lx < {1'b0, w_out_w};
      if (w_vld[i]) begin
        if (w_xi >= w_src_w - ONE_W) begin
          w_src_x[i*W_DIM +: W_DIM] = w_src_w - TWO_W;
          w_alpha[i*8 +: 8]         = 8'hFF;
        end else begin
          w_src_x[i*W_DIM +: W_DIM] = w_xi;
          w_alpha[i*8 +: 8]         = w_lacc[7:0];
        end
      end
      w_lacc = w_lacc + w_step_x;
    end
  end

  // Frame FSM with registered handshake outputs and descriptor
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_src_w     <= '0;
      r_src_h     <= '0;
      r_out_w     <= '0;
      r_out_h     <= '0;
      r_step_x    <= '0;
      r_step_y    <= '0;
      r_acc_x     <= '0;
      r_acc_y     <= '0;
      fetch_req   <= 1'b0;
      batch_start <= 1'b0;
      lane_valid  <= '0;
      lane_src_x  <= '0;
      lane_alpha  <= '0;
      src_y       <= '0;
      beta        <= '0;
      dst_x       <= '0;
      dst_y       <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      batch_start <= 1'b0;
      frame_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cfg_start) begin
            r_state <= S_INIT;
            busy    <= 1'b1;
          end
        end
        S_INIT, S_ADVANCE: begin
          if (r_state == S_INIT) begin
            r_src_w  <= cfg_src_w;
            r_src_h  <= cfg_src_h;
            r_out_w  <= cfg_out_w;
            r_out_h  <= cfg_out_h;
            r_step_x <= w_step_x;
            r_step_y <= w_step_y;
          end
          if ((r_state == S_INIT) ? w_empty : w_frame_end) begin
            r_state    <= S_DONE;
            frame_done <= 1'b1;
          end else begin
            r_state    <= S_FETCH;
            fetch_req  <= 1'b1;
            r_acc_x    <= w_nx_acc_x;
            r_acc_y    <= w_nx_acc_y;
            dst_x      <= w_nx_dst_x;
            dst_y      <= w_nx_dst_y;
            lane_valid <= w_vld;
            lane_src_x <= w_src_x;
            lane_alpha <= w_alpha;
            src_y      <= w_src_y;
            beta       <= w_beta;
          end
        end
        S_FETCH: begin
          if (fetch_ack) begin
            r_state     <= S_ISSUE;
            fetch_req   <= 1'b0;
            batch_start <= 1'b1;
          end
        end
        S_ISSUE: r_state <= S_WAIT;
        S_WAIT: begin
          if (batch_done) r_state <= S_ADVANCE;
        end
        S_DONE: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
